wb_word2byte: RTL and testbench
===============================

Name: wb_word2byte

Overview:
- Width adapter directly upstream of the SPI memory bridge.
- Accepts 32-bit Wishbone classic reads/writes with byte selects from the Levenshtein engine / host side.
- Splits each access into sequential 8-bit Wishbone cycles on a 23-bit byte address, which the SPI bridge consumes one byte per transfer.
- Assembles read bytes back into a word and returns a single acknowledge.

Parameters:
- ADR_WIDTH, 23, master-side byte address width.
- BYTES, 4, byte lanes per slave word; power of two. Slave address width is ADR_WIDTH - log2(BYTES).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- s_cyc_i  in  1  slave cycle
- s_stb_i  in  1  slave strobe
- s_adr_i  in  ADR_WIDTH-2  word address
- s_we_i  in  1  write enable
- s_sel_i  in  BYTES  byte-lane select; lane n = byte offset n (little-endian)
- s_dat_i  in  8*BYTES  write data
- s_ack_o  out  1  slave acknowledge
- s_err_o  out  1  slave error
- s_dat_o  out  8*BYTES  read data
- m_cyc_o  out  1  master cycle
- m_stb_o  out  1  master strobe
- m_adr_o  out  ADR_WIDTH  byte address = {s_adr_i, lane}
- m_we_o  out  1  master write enable
- m_dat_o  out  8  master write byte
- m_ack_i  in  1  master acknowledge
- m_err_i  in  1  master error
- m_dat_i  in  8  master read byte

Behaviour:
- Reset: clk_i single clock; rst_ni asynchronous, active-low. All outputs are 0 and the state is IDLE.
- State machine: IDLE, REQ, GAP, DONE.
- IDLE:
  - On s_cyc_i & s_stb_i, latch adr/we/sel/dat.
  - Clear the read-assembly register.
  - If sel != 0, go to REQ with the lowest selected lane.
  - If sel == 0, go to DONE with no master traffic.
- REQ:
  - m_cyc_o = m_stb_o = 1; m_adr_o, m_we_o and m_dat_o reflect the current lane. All are registered and stable for the whole cycle.
  - On m_ack_i: store m_dat_i into the lane's byte of the read register (reads only). If more selected lanes remain, go to GAP; otherwise go to DONE.
  - On m_err_i: set the error flag and go to DONE. Remaining lanes are skipped.
- GAP:
  - m_cyc_o = m_stb_o = 0 for exactly one cycle, so the bridge deasserts ss_n between bytes.
  - Advance to the next higher selected lane, skipping unselected lanes, then go to REQ.
- DONE:
  - s_ack_o = 1 (or s_err_o = 1 if the error flag is set) for exactly one cycle.
  - s_dat_o presents the assembled word; unselected lanes read 0.
  - Go to IDLE. s_stb_i is ignored during DONE.
- Latency:
  - Request sampled in IDLE at T gives m_stb_o high at T+1.
  - m_ack_i sampled at A gives the next lane's m_stb_o at A+2, or s_ack_o at A+1 after the last lane.
  - sel == 0 gives s_ack_o at T+1.
- s_dat_o holds its value until the next accepted request. During writes s_dat_o is 0.
- Abort: if s_cyc_i is low while in REQ or GAP, drop m_cyc_o/m_stb_o the next cycle and return to IDLE. No s_ack_o or s_err_o is issued, and already-written bytes are not undone.
- Simultaneous m_ack_i and m_err_i: error wins.
- Simultaneous m_ack_i and s_cyc_i low: abort wins; no s_ack_o.
- Address arithmetic: the lane index is concatenated, never added, so no carry or wrap. Word 0x1FFFFF lane 3 gives byte address 0x7FFFFF.
- Reset asserted mid-operation: outputs clear immediately (asynchronous); state returns to IDLE.

Test Plan:
- Read, sel=4'hF, adr=0x000010, bytes 0x11,0x22,0x33,0x44 returned at byte addresses 0x40..0x43 → four master cycles in ascending address order, one-cycle gap between each, s_dat_o=0x44332211, one s_ack_o pulse.
- Write, sel=4'b0101, dat=0xAABBCCDD, adr=0x000001 → exactly two master writes: 0x000004 with byte 0xDD, then 0x000006 with byte 0xBB; s_ack_o once.
- sel=0 read → no m_cyc_o activity, s_ack_o at T+1, s_dat_o=0.
- Read sel=4'hF with m_err_i on the second byte → no third byte issued; s_err_o pulses once; s_ack_o stays 0.
- s_cyc_i dropped while the second byte is waiting for m_ack_i → m_cyc_o low the next cycle, state IDLE, no s_ack_o; a following read then completes correctly.
- rst_ni pulsed low mid-REQ, asynchronous to the clock → m_cyc_o/m_stb_o drop before the next clock edge; post-reset access at word 0x1FFFFF lane 3 drives m_adr_o=0x7FFFFF.

Source files
------------

// File: rtl/wb_word2byte.sv
// Width adapter: one 32-bit Wishbone classic access becomes a run of 8-bit
// Wishbone cycles, one per selected byte lane, with a single returned ack.
module wb_word2byte #(
    parameter int ADR_WIDTH = 23,
    parameter int BYTES     = 4,
    localparam int LW       = $clog2(BYTES),
    localparam int SAW      = ADR_WIDTH - LW
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 s_cyc_i,
    input  logic                 s_stb_i,
    input  logic [SAW-1:0]       s_adr_i,
    input  logic                 s_we_i,
    input  logic [BYTES-1:0]     s_sel_i,
    input  logic [8*BYTES-1:0]   s_dat_i,
    output logic                 s_ack_o,
    output logic                 s_err_o,
    output logic [8*BYTES-1:0]   s_dat_o,
    output logic                 m_cyc_o,
    output logic                 m_stb_o,
    output logic [ADR_WIDTH-1:0] m_adr_o,
    output logic                 m_we_o,
    output logic [7:0]           m_dat_o,
    input  logic                 m_ack_i,
    input  logic                 m_err_i,
    input  logic [7:0]           m_dat_i
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;

    state_t               state_q, state_d;
    logic [SAW-1:0]       adr_q, adr_d;
    logic                 we_q, we_d;
    logic [BYTES-1:0]     sel_q, sel_d;
    logic [8*BYTES-1:0]   dat_q, dat_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic [8*BYTES-1:0]   rdat_q, rdat_d;
    logic                 err_q, err_d;
    logic                 m_cyc_q, m_cyc_d;
    logic [ADR_WIDTH-1:0] m_adr_q, m_adr_d;
    logic                 m_we_q, m_we_d;
    logic [7:0]           m_dat_q, m_dat_d;
    logic                 s_ack_q, s_ack_d;
    logic                 s_err_q, s_err_d;
    logic [BYTES-1:0]     rem;

    function automatic logic [LW-1:0] lowest_lane(input logic [BYTES-1:0] v);
        lowest_lane = '0;
        for (int i = BYTES - 1; i >= 0; i--) begin
            if (v[i]) lowest_lane = LW'(i);
        end
    endfunction

    // Selected lanes strictly above the one currently being transferred.
    always_comb begin
        rem = '0;
        for (int i = 0; i < BYTES; i++) begin
            rem[i] = sel_q[i] && (i > int'(lane_q));
        end
    end

    // Slave side: a request is taken when s_cyc_i & s_stb_i are seen in IDLE and
    // is answered by exactly one s_ack_o/s_err_o pulse; dropping s_cyc_i aborts
    // silently. Master side: m_stb_o holds until m_ack_i or m_err_i is sampled.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        lane_d  = lane_q;
        rdat_d  = rdat_q;
        err_d   = err_q;
        m_adr_d = m_adr_q;
        m_we_d  = m_we_q;
        m_dat_d = m_dat_q;
        case (state_q)
            IDLE: begin
                if (s_cyc_i && s_stb_i) begin
                    adr_d  = s_adr_i;
                    we_d   = s_we_i;
                    sel_d  = s_sel_i;
                    dat_d  = s_dat_i;
                    rdat_d = '0;
                    err_d  = 1'b0;
                    if (s_sel_i != '0) begin
                        lane_d  = lowest_lane(s_sel_i);
                        state_d = REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            REQ: begin
                // Abort outranks error, which outranks ack.
                if (!s_cyc_i) begin
                    state_d = IDLE;
                end else if (m_err_i) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (m_ack_i) begin
                    if (!we_q) rdat_d[lane_q*8 +: 8] = m_dat_i;
                    state_d = (rem != '0) ? GAP : DONE;
                end
            end
            GAP: begin
                if (!s_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    lane_d  = lowest_lane(rem);
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        m_cyc_d = (state_d == REQ);
        if (state_d == REQ) begin
            m_adr_d = {adr_d, lane_d};
            m_we_d  = we_d;
            m_dat_d = dat_d[lane_d*8 +: 8];
        end
        s_ack_d = (state_d == DONE) && !err_d;
        s_err_d = (state_d == DONE) && err_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            lane_q  <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
            m_cyc_q <= 1'b0;
            m_adr_q <= '0;
            m_we_q  <= 1'b0;
            m_dat_q <= '0;
            s_ack_q <= 1'b0;
            s_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            lane_q  <= lane_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
            m_cyc_q <= m_cyc_d;
            m_adr_q <= m_adr_d;
            m_we_q  <= m_we_d;
            m_dat_q <= m_dat_d;
            s_ack_q <= s_ack_d;
            s_err_q <= s_err_d;
        end
    end

    assign m_cyc_o = m_cyc_q;
    assign m_stb_o = m_cyc_q;
    assign m_adr_o = m_adr_q;
    assign m_we_o  = m_we_q;
    assign m_dat_o = m_dat_q;
    assign s_ack_o = s_ack_q;
    assign s_err_o = s_err_q;
    assign s_dat_o = rdat_q;

endmodule

// File: tb/tb_wb_word2byte.sv
// Directed bench for wb_word2byte: the bench plays both the upstream word
// master and the downstream byte slave, cycle by cycle.
module tb_wb_word2byte;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_cyc, s_stb, s_we;
    logic [20:0] s_adr;
    logic [3:0]  s_sel;
    logic [31:0] s_dat_i;
    logic        s_ack, s_err;
    logic [31:0] s_dat_o;
    logic        m_cyc, m_stb, m_we;
    logic [22:0] m_adr;
    logic [7:0]  m_dat_o;
    logic        m_ack, m_err;
    logic [7:0]  m_dat_i;

    int passes = 0;
    int total  = 0;
    int n_ack  = 0;
    int n_err  = 0;
    int n_cyc  = 0;
    int b_ack, b_err, b_cyc;

    wb_word2byte dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_adr_i(s_adr), .s_we_i(s_we),
        .s_sel_i(s_sel), .s_dat_i(s_dat_i),
        .s_ack_o(s_ack), .s_err_o(s_err), .s_dat_o(s_dat_o),
        .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_adr_o(m_adr), .m_we_o(m_we),
        .m_dat_o(m_dat_o), .m_ack_i(m_ack), .m_err_i(m_err), .m_dat_i(m_dat_i)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (s_ack) n_ack++;
        if (s_err) n_err++;
        if (m_cyc) n_cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic mark();
        b_ack = n_ack;
        b_err = n_err;
        b_cyc = n_cyc;
    endtask

    task automatic req(input logic [20:0] adr, input logic we, input logic [3:0] sel,
                       input logic [31:0] dat);
        s_cyc = 1'b1; s_stb = 1'b1; s_adr = adr; s_we = we; s_sel = sel; s_dat_i = dat;
        tick();
    endtask

    task automatic end_req();
        s_cyc = 1'b0; s_stb = 1'b0;
    endtask

    // Checks the current byte request, then answers it for one cycle.
    task automatic serve(input string tag, input logic [22:0] adr, input logic we,
                         input logic [7:0] wdat, input logic [7:0] rdat, input logic err);
        chk({tag, " m_cyc"}, 64'(m_cyc), 64'd1);
        chk({tag, " m_stb"}, 64'(m_stb), 64'd1);
        chk({tag, " m_adr"}, 64'(m_adr), 64'(adr));
        chk({tag, " m_we"}, 64'(m_we), 64'(we));
        if (we) chk({tag, " m_dat"}, 64'(m_dat_o), 64'(wdat));
        m_ack = !err; m_err = err; m_dat_i = rdat;
        tick();
        m_ack = 1'b0; m_err = 1'b0; m_dat_i = 8'h00;
    endtask

    logic [7:0] rb [4];

    initial begin
        rst_n = 1'b0; s_cyc = 0; s_stb = 0; s_we = 0; s_adr = '0; s_sel = '0;
        s_dat_i = '0; m_ack = 0; m_err = 0; m_dat_i = '0;
        #2;
        chk("rst s_ack", 64'(s_ack), 64'd0);
        chk("rst s_err", 64'(s_err), 64'd0);
        chk("rst s_dat", 64'(s_dat_o), 64'd0);
        chk("rst m_cyc", 64'(m_cyc), 64'd0);
        chk("rst m_stb", 64'(m_stb), 64'd0);
        chk("rst m_adr", 64'(m_adr), 64'd0);
        chk("rst state", 64'(dut.state_q), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Full-word read, ascending lanes with a gap between bytes.
        rb[0] = 8'h11; rb[1] = 8'h22; rb[2] = 8'h33; rb[3] = 8'h44;
        mark();
        req(21'h000010, 1'b0, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            serve("rd", 23'(23'h40 + i), 1'b0, 8'h00, rb[i], 1'b0);
            if (i < 3) begin
                chk("rd gap m_stb", 64'(m_stb), 64'd0);
                chk("rd gap s_ack", 64'(s_ack), 64'd0);
                tick();
            end
        end
        chk("rd s_ack", 64'(s_ack), 64'd1);
        chk("rd s_err", 64'(s_err), 64'd0);
        chk("rd s_dat", 64'(s_dat_o), 64'h44332211);
        chk("rd m_cyc idle", 64'(m_cyc), 64'd0);
        end_req();
        tick();
        chk("rd s_ack drop", 64'(s_ack), 64'd0);
        chk("rd s_dat hold", 64'(s_dat_o), 64'h44332211);
        chk("rd ack count", 64'(n_ack - b_ack), 64'd1);
        chk("rd byte count", 64'(n_cyc - b_cyc), 64'd4);

        // Sparse write: lanes 0 and 2 only.
        mark();
        req(21'h000001, 1'b1, 4'b0101, 32'hAABBCCDD);
        serve("wr0", 23'h000004, 1'b1, 8'hDD, 8'h00, 1'b0);
        chk("wr gap m_stb", 64'(m_stb), 64'd0);
        tick();
        serve("wr2", 23'h000006, 1'b1, 8'hBB, 8'h00, 1'b0);
        chk("wr s_ack", 64'(s_ack), 64'd1);
        chk("wr s_dat", 64'(s_dat_o), 64'd0);
        end_req();
        tick();
        chk("wr ack count", 64'(n_ack - b_ack), 64'd1);
        chk("wr byte count", 64'(n_cyc - b_cyc), 64'd2);

        // Empty select: immediate ack, no master traffic.
        mark();
        req(21'h000123, 1'b0, 4'h0, 32'h0);
        chk("sel0 s_ack", 64'(s_ack), 64'd1);
        chk("sel0 s_dat", 64'(s_dat_o), 64'd0);
        chk("sel0 m_cyc", 64'(m_cyc), 64'd0);
        end_req();
        tick();
        chk("sel0 s_ack drop", 64'(s_ack), 64'd0);
        chk("sel0 byte count", 64'(n_cyc - b_cyc), 64'd0);

        // Error on the second byte: remaining lanes skipped, s_err_o once.
        mark();
        req(21'h000020, 1'b0, 4'hF, 32'h0);
        serve("err0", 23'h000080, 1'b0, 8'h00, 8'h55, 1'b0);
        tick();
        m_ack = 1'b1;
        serve("err1", 23'h000081, 1'b0, 8'h00, 8'h66, 1'b1);
        chk("err s_err", 64'(s_err), 64'd1);
        chk("err s_ack", 64'(s_ack), 64'd0);
        chk("err m_cyc", 64'(m_cyc), 64'd0);
        end_req();
        tick(); tick();
        chk("err m_cyc quiet", 64'(m_cyc), 64'd0);
        chk("err err count", 64'(n_err - b_err), 64'd1);
        chk("err ack count", 64'(n_ack - b_ack), 64'd0);
        chk("err byte count", 64'(n_cyc - b_cyc), 64'd2);

        // Abort while byte 1 waits, with a coincident ack: abort wins.
        mark();
        req(21'h000030, 1'b0, 4'hF, 32'h0);
        serve("ab0", 23'h0000C0, 1'b0, 8'h00, 8'h77, 1'b0);
        tick();
        chk("ab wait m_stb", 64'(m_stb), 64'd1);
        chk("ab wait m_adr", 64'(m_adr), 64'h0000C1);
        tick();
        chk("ab hold m_stb", 64'(m_stb), 64'd1);
        s_cyc = 1'b0; s_stb = 1'b0; m_ack = 1'b1; m_dat_i = 8'h88;
        tick();
        m_ack = 1'b0; m_dat_i = 8'h00;
        chk("ab m_cyc", 64'(m_cyc), 64'd0);
        chk("ab m_stb", 64'(m_stb), 64'd0);
        chk("ab state", 64'(dut.state_q), 64'd0);
        tick();
        chk("ab ack count", 64'(n_ack - b_ack), 64'd0);
        chk("ab err count", 64'(n_err - b_err), 64'd0);

        // Follow-up read of lane 1 only; other lanes read as zero.
        req(21'h000031, 1'b0, 4'b0010, 32'h0);
        serve("ab rd", 23'h0000C5, 1'b0, 8'h00, 8'h9A, 1'b0);
        chk("ab rd s_ack", 64'(s_ack), 64'd1);
        chk("ab rd s_dat", 64'(s_dat_o), 64'h00009A00);
        end_req();
        tick();

        // Asynchronous reset in the middle of a byte request.
        req(21'h000005, 1'b0, 4'hF, 32'h0);
        chk("rs pre m_stb", 64'(m_stb), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs m_cyc", 64'(m_cyc), 64'd0);
        chk("rs m_stb", 64'(m_stb), 64'd0);
        chk("rs state", 64'(dut.state_q), 64'd0);
        end_req();
        #2 rst_n = 1'b1;
        tick();

        // Top word, top lane: concatenated address reaches 0x7FFFFF.
        req(21'h1FFFFF, 1'b0, 4'b1000, 32'h0);
        serve("top", 23'h7FFFFF, 1'b0, 8'h00, 8'hEE, 1'b0);
        chk("top s_ack", 64'(s_ack), 64'd1);
        chk("top s_dat", 64'(s_dat_o), 64'hEE000000);
        end_req();
        tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
